// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and default width.
package serial_add_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder reused every cycle by the serial datapath.
module fa_cell (
  input  logic ai,
  input  logic bi,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = ai ^ bi ^ ci;
  assign co = (ai & bi) | ((ai | bi) & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell walked LSB-first over WIDTH cycles,
// with a start/busy/done handshake and registered result flags.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             ovf,
  output logic             zf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIDTH - 2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sf_q, sf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d, cmsb_q, cmsb_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zf_q, zf_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             s_w, co_w;

  fa_cell u_fa (
    .ai (sa_q[0]),
    .bi (sb_q[0]),
    .ci (c_q),
    .s  (s_w),
    .co (co_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sf_q    <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cmsb_q  <= 1'b0;
      f_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zf_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sf_q    <= sf_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cmsb_q  <= cmsb_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zf_q    <= zf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sf_d    = sf_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cmsb_d  = cmsb_q;
    f_d     = f_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zf_d    = zf_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Subtraction is A + ~B + 1: invert B and force the initial carry.
        if (start) begin
          sa_d    = a;
          sb_d    = op_sub ? ~b : b;
          c_d     = op_sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sf_d  = {s_w, sf_q[WIDTH-1:1]};
        c_d   = co_w;
        cnt_d = cnt_q + CNT_W'(1);
        // The carry produced by bit WIDTH-2 is the carry into the MSB, needed for overflow.
        if (cnt_q == CNT_PRE) cmsb_d = co_w;
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        f_d     = sf_q;
        cout_d  = c_q;
        ovf_d   = cmsb_q ^ c_q;
        zf_d    = (sf_q == '0);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign f    = f_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zf   = zf_q;

endmodule
